input_debounce: RTL and testbench

//  Upstream conditioner for the single-bit level-tracking FSM: takes an asynchronous raw input
//  (button/pin), synchronises it, filters bounce, and drives the FSM's clean `a` input.

---
 rtl/fsm_common_pkg.sv | 17 +
 rtl/sync_chain.sv | 24 ++
 rtl/input_debounce.sv | 91 +++++++++
 tb/tb_input_debounce.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_common_pkg.sv
// rtl/fsm_common_pkg.sv - state encodings and constants shared by the debouncer and level FSM
package fsm_common_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_CONFIRM = 1'b1
    } deb_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Level-tracking FSM fed by level_out
    typedef enum logic {
        LV_LOW  = 1'b0,
        LV_HIGH = 1'b1
    } lvl_state_t;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for one asynchronous pin
module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_LEVEL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - synchronise, debounce and edge-detect one raw input pin
module input_debounce
    import fsm_common_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = 1'b0,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    deb_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             level_n;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_in),
        .q     (s)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = level_out;
        case (state)
            ST_STABLE: begin
                cnt_n = '0;
                if (s != level_out) begin
                    // A single-sample filter accepts the change without entering CONFIRM
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_n = s;
                    end else begin
                        cnt_n   = CNT_ONE;
                        state_n = ST_CONFIRM;
                    end
                end
            end
            ST_CONFIRM: begin
                if (s == level_out) begin
                    cnt_n   = '0;
                    state_n = ST_STABLE;
                end else if (cnt == CNT_LAST) begin
                    level_n = s;
                    cnt_n   = '0;
                    state_n = ST_STABLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_STABLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_STABLE;
            cnt        <= '0;
            level_out  <= RESET_LEVEL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            level_out  <= level_n;
            rise_pulse <= level_n & ~level_out;
            fall_pulse <= ~level_n & level_out;
            busy       <= (state_n == ST_CONFIRM);
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
// tb/tb_input_debounce.sv - directed self-checking bench for input_debounce
module tb_input_debounce;

    logic clk = 1'b0;
    logic rst_n, raw;
    logic level, rise, fall, busy;
    logic rst1_n, raw1;
    logic level1, rise1, fall1, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    input_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_LEVEL     (1'b0)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw),
        .level_out  (level),
        .rise_pulse (rise),
        .fall_pulse (fall),
        .busy       (busy)
    );

    input_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .RESET_LEVEL     (1'b1)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst1_n),
        .raw_in     (raw1),
        .level_out  (level1),
        .rise_pulse (rise1),
        .fall_pulse (fall1),
        .busy       (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic v);
        rst_n = 1'b0;
        raw   = v;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] busy_tr, lvl_tr, rise_tr, fall_tr;
        int strobes;
        int hist [0:48];

        // 1: reset with raw high, then release
        rst_n = 1'b0; raw = 1'b1; rst1_n = 1'b0; raw1 = 1'b1;
        #23;
        check("t1_reset_outs", {28'd0, level, rise, fall, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) check("t1_level_e5", level, 0);
            if (i == 6) check("t1_rise_e6", rise, 1);
            strobes += rise + fall;
        end
        check("t1_strobe_count", strobes, 1);

        // 2: clean rising edge
        reset_dut(1'b0);
        raw = 1'b1;
        busy_tr = '0; lvl_tr = '0; rise_tr = '0; fall_tr = '0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            busy_tr[i-1] = busy; lvl_tr[i-1] = level;
            rise_tr[i-1] = rise; fall_tr[i-1] = fall;
        end
        check("t2_busy_trace", busy_tr, 16'h001C);
        check("t2_level_trace", lvl_tr, 16'h00E0);
        check("t2_rise_trace", rise_tr, 16'h0020);
        check("t2_fall_trace", fall_tr, 16'h0000);

        // 3: one-sample bounce restarts confirmation
        reset_dut(1'b0);
        busy_tr = '0; lvl_tr = '0; rise_tr = '0; fall_tr = '0;
        for (int i = 1; i <= 14; i++) begin
            raw = (i == 4) ? 1'b0 : 1'b1;
            tick();
            busy_tr[i-1] = busy; lvl_tr[i-1] = level;
            rise_tr[i-1] = rise; fall_tr[i-1] = fall;
        end
        check("t3_level_e6", lvl_tr[5], 0);
        check("t3_level_trace", lvl_tr, 16'h3E00);
        check("t3_busy_trace", busy_tr, 16'h01DC);
        check("t3_rise_trace", rise_tr, 16'h0200);
        check("t3_fall_trace", fall_tr, 16'h0000);

        // 4: asynchronous reset in the middle of confirmation
        reset_dut(1'b0);
        raw = 1'b1;
        repeat (4) tick();
        check("t4_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_outs", {28'd0, level, rise, fall, busy}, 32'd0);
        raw = 1'b0;
        #2;
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            strobes += rise + fall + busy;
        end
        check("t4_no_activity", strobes, 0);
        check("t4_level", level, 0);

        // 5: single-cycle filter, reset level high
        check("t5_reset_outs", {28'd0, level1, rise1, fall1, busy1}, 32'h8);
        rst1_n = 1'b1;
        strobes = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            strobes += rise1 + fall1 + busy1;
        end
        check("t5_idle_quiet", strobes, 0);
        check("t5_idle_level", level1, 1);
        raw1 = 1'b0;
        busy_tr = '0; lvl_tr = '0; rise_tr = '0; fall_tr = '0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            busy_tr[i-1] = busy1; lvl_tr[i-1] = level1;
            rise_tr[i-1] = rise1; fall_tr[i-1] = fall1;
        end
        check("t5_level_trace", lvl_tr, 16'h0003);
        check("t5_fall_trace", fall_tr, 16'h0004);
        check("t5_rise_trace", rise_tr, 16'h0000);
        check("t5_busy_trace", busy_tr, 16'h0000);

        // 6: toggle every 6 cycles; level follows raw delayed by 5 edges
        reset_dut(1'b0);
        hist[0] = 0;
        for (int n = 1; n <= 48; n++) begin
            raw = (n <= 40) ? logic'(((n - 1) / 6) % 2) : raw;
            hist[n] = int'(raw);
            tick();
            if (n >= 6) begin
                check($sformatf("t6_level_e%0d", n), level, hist[n-5]);
                check($sformatf("t6_rise_e%0d", n), rise,
                      (hist[n-5] == 1 && hist[n-6] == 0) ? 1 : 0);
                check($sformatf("t6_fall_e%0d", n), fall,
                      (hist[n-5] == 0 && hist[n-6] == 1) ? 1 : 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
